// File: rtl/ram4k_block_mover.sv
// Block copy / fill engine driving a single RAM4K port, one access per cycle.
// Every mem_* output comes from a flop, so start has no combinational path to the RAM.
module ram4k_block_mover (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [11:0] src,
  input  logic [11:0] dst,
  input  logic [12:0] len,
  input  logic [15:0] fill_data,
  output logic        busy,
  output logic        done,
  output logic [12:0] words_done,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_in,
  input  logic [15:0] mem_out
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_FILL, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [11:0] src_q, src_d;
  logic [11:0] dst_q, dst_d;
  logic [12:0] rem_q, rem_d;
  logic [15:0] data_q, data_d;
  logic [15:0] fill_q, fill_d;
  logic [12:0] words_done_q, words_done_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_rw_q, mem_rw_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_in_q, mem_in_d;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    data_d       = data_q;
    fill_d       = fill_q;
    words_done_d = words_done_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d        = src;
          dst_d        = dst;
          rem_d        = len;
          fill_d       = fill_data;
          words_done_d = 13'd0;
          if (len == 13'd0)  state_d = S_DONE;
          else if (op)       state_d = S_FILL;
          else               state_d = S_READ;
        end
      end
      S_READ: begin
        data_d  = mem_out;
        src_d   = src_q + 12'd1;
        state_d = S_WRITE;
      end
      S_WRITE, S_FILL: begin
        dst_d        = dst_q + 12'd1;
        rem_d        = rem_q - 13'd1;
        words_done_d = words_done_q + 13'd1;
        if (rem_q == 13'd1)         state_d = S_DONE;
        else if (state_q == S_FILL) state_d = S_FILL;
        else                        state_d = S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs for the coming cycle are decoded from the next-state values.
    busy_d     = 1'b0;
    done_d     = 1'b0;
    mem_en_d   = 1'b0;
    mem_rw_d   = 1'b0;
    mem_addr_d = 12'd0;
    mem_in_d   = 16'd0;
    case (state_d)
      S_READ: begin
        busy_d     = 1'b1;
        mem_en_d   = 1'b1;
        mem_addr_d = src_d;
      end
      S_WRITE: begin
        busy_d     = 1'b1;
        mem_en_d   = 1'b1;
        mem_rw_d   = 1'b1;
        mem_addr_d = dst_d;
        mem_in_d   = data_d;
      end
      S_FILL: begin
        busy_d     = 1'b1;
        mem_en_d   = 1'b1;
        mem_rw_d   = 1'b1;
        mem_addr_d = dst_d;
        mem_in_d   = fill_d;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      src_q        <= 12'd0;
      dst_q        <= 12'd0;
      rem_q        <= 13'd0;
      data_q       <= 16'd0;
      fill_q       <= 16'd0;
      words_done_q <= 13'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= 12'd0;
      mem_in_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      data_q       <= data_d;
      fill_q       <= fill_d;
      words_done_q <= words_done_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_in_q     <= mem_in_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = words_done_q;
  assign mem_en     = mem_en_q;
  assign mem_rw     = mem_rw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_in     = mem_in_q;

endmodule

// File: tb/tb_ram4k_block_mover.sv
// Bench for ram4k_block_mover: behavioural RAM4K plus a write scoreboard.
module tb_ram4k_block_mover;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [11:0] src, dst;
  logic [12:0] len;
  logic [15:0] fill_data;
  logic        busy, done, mem_en, mem_rw;
  logic [12:0] words_done;
  logic [11:0] mem_addr;
  logic [15:0] mem_in, mem_out;
  logic        init_mem;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic [15:0] ram [0:4095];

  always #5 clk = ~clk;

  ram4k_block_mover dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src(src), .dst(dst),
    .len(len), .fill_data(fill_data), .busy(busy), .done(done),
    .words_done(words_done), .mem_en(mem_en), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out)
  );

  function automatic logic [15:0] init_val(input int i);
    logic [15:0] v;
    if (i >= 16 && i < 24) v = 16'(32'h1111 * (i - 15));
    else                   v = 16'hC000 | 16'(i & 32'hFFF);
    return v;
  endfunction

  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
    else if (mem_en && mem_rw) ram[mem_addr] <= mem_in;
  end
  assign mem_out = mem_en ? ram[mem_addr] : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Every RAM write must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (!init_mem && mem_en && mem_rw) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_write observed=%h:%h expected=no write", mem_addr, mem_in);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("ram_write", {4'h0, mem_addr, mem_in}, {4'h0, e.a, e.d});
      end
    end
  end

  task automatic push_wr(input logic [11:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Returns at the falling edge inside cycle 1 after the accepting edge.
  task automatic kick(input logic o, input logic [11:0] s, input logic [11:0] d,
                      input logic [12:0] l, input logic [15:0] f);
    @(negedge clk);
    op = o; src = s; dst = d; len = l; fill_data = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc, output int busy_n, output int en_n);
    cyc = cyc0; busy_n = 0; en_n = 0;
    forever begin
      if (busy) busy_n++;
      if (mem_en) en_n++;
      if (done || cyc >= 200) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bn, en;
    reset = 1'b1; start = 1'b0; op = 1'b0; src = '0; dst = '0; len = '0;
    fill_data = '0; init_mem = 1'b0;
    @(negedge clk); init_mem = 1'b1;
    @(negedge clk); init_mem = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    chk("rst_mem", {13'd0, mem_en, mem_rw, mem_addr, mem_in[0]}, 32'd0);
    chk("rst_mem_in", 32'(mem_in), 32'd0);
    reset = 1'b0;

    // Copy 4 words 0x010 -> 0x800
    for (int i = 0; i < 4; i++) push_wr(12'h800 + 12'(i), init_val(16 + i));
    kick(1'b0, 12'h010, 12'h800, 13'd4, 16'h0);
    wait_done(1, cyc, bn, en);
    chk("copy_done_cycle", 32'(cyc), 32'd9);
    chk("copy_busy_cycles", 32'(bn), 32'd8);
    chk("copy_words_done", 32'(words_done), 32'd4);
    chk("copy_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("copy_dst", 32'(ram[12'h800 + 12'(i)]), 32'(init_val(16 + i)));
      chk("copy_src_kept", 32'(ram[16 + i]), 32'(init_val(16 + i)));
    end

    // Fill 3 words at 0x100
    for (int i = 0; i < 3; i++) push_wr(12'h100 + 12'(i), 16'hA5A5);
    kick(1'b1, 12'h000, 12'h100, 13'd3, 16'hA5A5);
    wait_done(1, cyc, bn, en);
    chk("fill_done_cycle", 32'(cyc), 32'd4);
    chk("fill_busy_cycles", 32'(bn), 32'd3);
    chk("fill_words_done", 32'(words_done), 32'd3);
    chk("fill_last", 32'(ram[12'h102]), 32'hA5A5);
    chk("fill_untouched", 32'(ram[12'h103]), 32'(init_val(12'h103)));

    // Fill wrapping past 0xFFF
    push_wr(12'hFFE, 16'h0F0F); push_wr(12'hFFF, 16'h0F0F);
    push_wr(12'h000, 16'h0F0F); push_wr(12'h001, 16'h0F0F);
    kick(1'b1, 12'h000, 12'hFFE, 13'd4, 16'h0F0F);
    wait_done(1, cyc, bn, en);
    chk("wrap_done_cycle", 32'(cyc), 32'd5);
    chk("wrap_ram0", 32'(ram[0]), 32'h0F0F);
    chk("wrap_untouched", 32'(ram[2]), 32'(init_val(2)));
    chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length request
    kick(1'b1, 12'h000, 12'h400, 13'd0, 16'h7777);
    wait_done(1, cyc, bn, en);
    chk("len0_done_cycle", 32'(cyc), 32'd1);
    chk("len0_mem_en", 32'(en), 32'd0);
    chk("len0_words_done", 32'(words_done), 32'd0);

    // Start pulsed while busy must be ignored
    for (int i = 0; i < 4; i++) push_wr(12'h300 + 12'(i), 16'h1234);
    kick(1'b1, 12'h000, 12'h300, 13'd4, 16'h1234);
    op = 1'b1; dst = 12'h200; len = 13'd1; fill_data = 16'hBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, cyc, bn, en);
    chk("busy_start_done_cycle", 32'(cyc), 32'd5);
    chk("busy_start_words_done", 32'(words_done), 32'd4);
    chk("busy_start_ignored", 32'(ram[12'h200]), 32'(init_val(12'h200)));
    @(negedge clk);
    chk("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during the second READ of an 8-word copy
    push_wr(12'h900, init_val(16));
    kick(1'b0, 12'h010, 12'h900, 13'd8, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_read1_addr", {19'd0, mem_en, mem_addr}, {19'd0, 1'b1, 12'h011});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_words_done", 32'(words_done), 32'd0);
    chk("midrst_mem", {2'd0, mem_en, mem_rw, mem_addr, mem_in}, 32'd0);
    bn = 0; en = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) bn++;
      if (mem_en) en++;
      @(negedge clk);
    end
    chk("midrst_no_done", 32'(bn), 32'd0);
    chk("midrst_no_access", 32'(en), 32'd0);
    chk("midrst_word0", 32'(ram[12'h900]), 32'h1111);
    chk("midrst_word1", 32'(ram[12'h901]), 32'(init_val(12'h901)));
    chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Fresh copy after reset
    push_wr(12'h910, init_val(20)); push_wr(12'h911, init_val(21));
    kick(1'b0, 12'h014, 12'h910, 13'd2, 16'h0);
    wait_done(1, cyc, bn, en);
    chk("fresh_done_cycle", 32'(cyc), 32'd5);
    chk("fresh_words_done", 32'(words_done), 32'd2);
    chk("fresh_queue_empty", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
